mm_controller: RTL and testbench
================================

# mm_controller

Control unit for the interleaved modular multiplier; computes C = A·B mod N on the existing datapath. Accepts a start request, sequences the datapath one multiplier bit per four cycles (MSB first), and pulses done when C holds the result. It drives the 15-bit control bus and consumes the 3-bit status bus, so it sits directly beside the datapath inside the multiplier top level.

## Interface
- No parameters. Operand width is fixed at 8 by the datapath, giving 8 bit-steps.
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a multiplication. Sampled in IDLE only.
- Status_Signal  in  3  [2] counter==0, [1] C>=N (compare select 00), [0] current B MSB.
- Control_Signal  out  15  [14]LoadA [13]LoadN [12]LoadCoun [11]LoadB [10]ShiftB [9]LoadC [8]ShiftC [7]S_Coun [6]S_Comp1 [5]S_Comp2 [4]S_AS1 [3:2]S_AS2 [1]S_C [0]AS.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; the datapath C is valid while done is high.
- abort  in  1  present only with MM_CTRL_ABORT_EN.

## Operation
- Datapath encodings driven by this block:
  - S_C=1 loads zero into C; S_C=0 loads the adder output.
  - S_AS1: 0 selects C, 1 selects C<<1.
  - S_AS2: 00 selects A, 01 selects N, 10 selects zero. 11 is never driven.
  - AS: 0 adds, 1 subtracts.
  - S_Coun: 0 loads the counter with 8, 1 decrements it.
  - Compare select {S_Comp1,S_Comp2} is held at 00. ShiftC is held at 0.
- States and their Control_Signal values:
  - IDLE: 0x0000. Go to LOAD if start=1.
  - LOAD: 0x7A02 (load A, N, B and the counter; clear C). Go to DBL.
  - DBL: 0x0218 (C <= 2C). Go to RED_D.
  - RED_D: 0x0205 (C <= C−N) if Status[1]=1, else 0x0000. Go to ADD.
  - ADD: 0x1680 if Status[0]=1 (C <= C+A, decrement counter, shift B). 0x1480 if Status[0]=0 (decrement and shift only). Go to RED_A.
  - RED_A: 0x0205 if Status[1]=1, else 0x0000. Go to DONE if Status[2]=1, else to DBL.
  - DONE: 0x0000, done=1. Go to IDLE.
- Control_Signal is a combinational decode of the state register and Status_Signal.
- busy and done decode from the state register only, so they are glitch-free.
- Operand precondition: A<N and N≠0. One conditional subtraction per step keeps C<N. The controller does not check this precondition.

## Timing
- Reset (rst=0): immediately enter IDLE. Control_Signal=0, busy=0, done=0.
- Reset mid-operation: abandon the operation and enter IDLE. No done pulse. Datapath contents are don't-care.
- Latency: start high in IDLE at cycle 0 gives LOAD at cycle 1, bit-steps at cycles 2–33, DONE (done=1) at cycle 34.
- Latency is fixed and independent of operand values.
- The next start is accepted at cycle 35 at the earliest.
- start while busy, including in DONE, is ignored and does not queue.
- RED_A sees the counter already decremented in ADD. Status[2]=1 in RED_A therefore marks the final bit.

## Configuration
- MM_CTRL_ABORT_EN defined:
  - abort port exists.
  - abort=1 in any busy state other than DONE forces IDLE on the next edge, with Control_Signal=0 in that cycle.
  - No done pulse follows.
  - abort in IDLE or DONE has no effect.
- MM_CTRL_ABORT_EN undefined: no abort port. The operation always runs to DONE.

## Structure
- Shared package mm_pkg holds:
  - the state enum;
  - Control_Signal bit-index localparams;
  - the S_AS2 encodings (SEL_A, SEL_N, SEL_ZERO);
  - Status_Signal bit indices;
  - the bus widths (15, 3).
- No sub-module. The block is a single FSM with a combinational output decoder.

## Test plan
- A=15, B=25, N=148 with controller and datapath, start pulsed: done exactly at cycle 34, C=79, busy high for cycles 1–34.
- A=97, B=15, N=113: C=99. A=50, B=0, N=113: C=0, and every ADD state drives 0x1480.
- Standalone controller with forced Status[1]=1 in RED_D: Control_Signal=0x0205. Forced Status[1]=0: 0x0000.
- start re-asserted at cycle 10 and in DONE: ignored, single done at cycle 34. rst low at cycle 20: outputs 0 immediately, IDLE, no done.
- MM_CTRL_ABORT_EN: abort at cycle 15 gives IDLE at cycle 16, busy=0, no done. A fresh start afterwards yields the correct C=79.

Source files
------------

// File: rtl/mm_pkg.sv
// mm_pkg: shared states, control/status bit positions and datapath encodings for mm_controller
package mm_pkg;

    localparam int CTRL_W = 15;
    localparam int STAT_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DBL,
        S_RED_D,
        S_ADD,
        S_RED_A,
        S_DONE
    } state_t;

    localparam int CB_LOAD_A    = 14;
    localparam int CB_LOAD_N    = 13;
    localparam int CB_LOAD_COUN = 12;
    localparam int CB_LOAD_B    = 11;
    localparam int CB_SHIFT_B   = 10;
    localparam int CB_LOAD_C    = 9;
    localparam int CB_SHIFT_C   = 8;
    localparam int CB_S_COUN    = 7;
    localparam int CB_S_COMP1   = 6;
    localparam int CB_S_COMP2   = 5;
    localparam int CB_S_AS1     = 4;
    localparam int CB_S_AS2_LO  = 2;
    localparam int CB_S_C       = 1;
    localparam int CB_AS        = 0;

    localparam logic [1:0] SEL_A    = 2'b00;
    localparam logic [1:0] SEL_N    = 2'b01;
    localparam logic [1:0] SEL_ZERO = 2'b10;

    localparam int ST_CNT_Z = 2;
    localparam int ST_GE_N  = 1;
    localparam int ST_B_MSB = 0;

endpackage

// File: rtl/mm_controller.sv
// mm_controller: FSM sequencing the interleaved modular multiplier datapath (optional abort via MM_CTRL_ABORT_EN)
module mm_controller
    import mm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef MM_CTRL_ABORT_EN
    input  logic              abort,
`endif
    input  logic [STAT_W-1:0] Status_Signal,
    output logic [CTRL_W-1:0] Control_Signal,
    output logic              busy,
    output logic              done
);

    state_t              r_state;
    state_t              w_next;
    logic                w_abort;
    logic [CTRL_W-1:0]   w_ctrl;

`ifdef MM_CTRL_ABORT_EN
    assign w_abort = abort && r_state != S_IDLE && r_state != S_DONE;
`else
    assign w_abort = 1'b0;
`endif

    // state register, async active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // next-state: fixed four-cycle bit-step loop until the counter hits zero in RED_A
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? S_LOAD : S_IDLE;
            S_LOAD:  w_next = S_DBL;
            S_DBL:   w_next = S_RED_D;
            S_RED_D: w_next = S_ADD;
            S_ADD:   w_next = S_RED_A;
            S_RED_A: w_next = Status_Signal[ST_CNT_Z] ? S_DONE : S_DBL;
            default: w_next = S_IDLE;
        endcase
        if (w_abort)
            w_next = S_IDLE;
    end

    // control decode from state and status; zero while an abort is taking effect
    always_comb begin
        w_ctrl = '0;
        case (r_state)
            S_LOAD: begin
                w_ctrl[CB_LOAD_A]    = 1'b1;
                w_ctrl[CB_LOAD_N]    = 1'b1;
                w_ctrl[CB_LOAD_COUN] = 1'b1;
                w_ctrl[CB_LOAD_B]    = 1'b1;
                w_ctrl[CB_LOAD_C]    = 1'b1;
                w_ctrl[CB_S_C]       = 1'b1;
            end
            S_DBL: begin
                w_ctrl[CB_LOAD_C]                    = 1'b1;
                w_ctrl[CB_S_AS1]                     = 1'b1;
                w_ctrl[CB_S_AS2_LO+1:CB_S_AS2_LO]    = SEL_ZERO;
            end
            S_RED_D, S_RED_A: begin
                w_ctrl[CB_LOAD_C]                    = Status_Signal[ST_GE_N];
                w_ctrl[CB_S_AS2_LO+1:CB_S_AS2_LO]    = Status_Signal[ST_GE_N] ? SEL_N : SEL_A;
                w_ctrl[CB_AS]                        = Status_Signal[ST_GE_N];
            end
            S_ADD: begin
                w_ctrl[CB_LOAD_COUN]                 = 1'b1;
                w_ctrl[CB_S_COUN]                    = 1'b1;
                w_ctrl[CB_SHIFT_B]                   = 1'b1;
                w_ctrl[CB_LOAD_C]                    = Status_Signal[ST_B_MSB];
                w_ctrl[CB_S_AS2_LO+1:CB_S_AS2_LO]    = SEL_A;
            end
            default: w_ctrl = '0;
        endcase
    end

    assign Control_Signal = w_abort ? '0 : w_ctrl;
    assign busy           = r_state != S_IDLE;
    assign done           = r_state == S_DONE;

endmodule

// File: tb/tb_mm_controller.sv
// tb_mm_controller: random modular multiplications through a datapath model, scoreboard-checked
module tb_mm_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  status;
    logic [14:0] ctrl;
    logic        busy;
    logic        done;

    logic        force_st = 1'b0;
    logic [2:0]  st_ovr = 3'b000;
    logic [7:0]  in_a = 8'd0, in_n = 8'd1, in_b = 8'd0;
    logic [7:0]  dA, dN, dB;
    logic [9:0]  dC, opnd1, opnd2, sum;
    logic [3:0]  dcnt;

    int cyc = 0;
    int op_s = -1;
    int op_end = -1;
    logic [7:0] op_b = 8'd0;
    int exp_q[$];
    int n_chk = 0;
    int n_fail = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    mm_controller dut (
        .clk(clk),
        .rst(rst),
        .start(start),
`ifdef MM_CTRL_ABORT_EN
        .abort(abort),
`endif
        .Status_Signal(status),
        .Control_Signal(ctrl),
        .busy(busy),
        .done(done)
    );

    // Behavioural datapath the controller drives
    assign opnd1  = ctrl[4] ? {dC[8:0], 1'b0} : dC;
    assign opnd2  = ctrl[3:2] == 2'b00 ? {2'b00, dA} : ctrl[3:2] == 2'b01 ? {2'b00, dN} : 10'd0;
    assign sum    = ctrl[0] ? opnd1 - opnd2 : opnd1 + opnd2;
    assign status = force_st ? st_ovr : {dcnt == 4'd0, dC >= {2'b00, dN}, dB[7]};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ctrl[14]) dA <= in_a;
        if (ctrl[13]) dN <= in_n;
        if (ctrl[11]) dB <= in_b;
        else if (ctrl[10]) dB <= {dB[6:0], 1'b0};
        if (ctrl[12]) dcnt <= ctrl[7] ? dcnt - 4'd1 : 4'd8;
        if (ctrl[9]) dC <= ctrl[1] ? 10'd0 : sum;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, expv);
        end
    endtask

    // Monitor: expected outputs derived from the op start cycle and the rules of the bit-step schedule
    always @(posedge clk) begin
        #2;
        if (mon_en) begin
            int d;
            logic act;
            d   = cyc - op_s;
            act = op_s >= 0 && d >= 1 && d <= 34 && cyc <= op_end;
            chk("busy", busy, act);
            chk("done", done, act && d == 34 && op_end == op_s + 34);
            if (!act)
                chk("ctrl_idle", ctrl, 0);
            else if (d == 1)
                chk("ctrl_load", ctrl, 32'h7A02);
            else if (d == 34)
                chk("ctrl_done", ctrl, 0);
            else if ((d - 2) % 4 == 0)
                chk("ctrl_dbl", ctrl, 32'h0218);
            else if ((d - 2) % 4 == 2)
                chk("ctrl_add", ctrl, op_b[7 - (d - 2) / 4] ? 32'h1680 : 32'h1480);
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL done_unexpected at cycle %0d: got done=1 expected none", cyc);
                end else
                    chk("result_C", dC, exp_q.pop_front());
            end
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n);
        @(negedge clk);
        in_a = a;
        in_b = b;
        in_n = n;
        start = 1'b1;
        op_s = cyc;
        op_end = cyc + 34;
        op_b = b;
        exp_q.push_back((int'(a) * int'(b)) % int'(n));
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #1;
        chk("reset_ctrl", ctrl, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        start_op(8'd15, 8'd25, 8'd148);
        wait_cyc(op_s + 3);
        force_st = 1'b1;
        st_ovr = 3'b010;
        #1 chk("red_d_ge", ctrl, 32'h0205);
        st_ovr = 3'b000;
        #1 chk("red_d_lt", ctrl, 32'h0000);
        force_st = 1'b0;
        wait_cyc(op_s + 10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(op_s + 34);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(op_s + 40);

        start_op(8'd97, 8'd15, 8'd113);
        wait_cyc(op_s + 34);
        start_op(8'd50, 8'd0, 8'd113);
        wait_cyc(op_s + 34);

        for (int i = 0; i < 8; i++) begin
            int n, a;
            n = $urandom_range(255, 1);
            a = $urandom_range(n - 1, 0);
            start_op(8'(a), 8'($urandom_range(255, 0)), 8'(n));
            wait_cyc(op_s + 34 + (i % 2) * 3);
        end
        wait_cyc(op_s + 38);

        start_op(8'd15, 8'd25, 8'd148);
        wait_cyc(op_s + 20);
        rst = 1'b0;
        #1;
        chk("midreset_ctrl", ctrl, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_done", done, 0);
        op_end = op_s + 20;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        wait_cyc(op_s + 40);

`ifdef MM_CTRL_ABORT_EN
        start_op(8'd15, 8'd25, 8'd148);
        wait_cyc(op_s + 15);
        abort = 1'b1;
        op_end = op_s + 15;
        void'(exp_q.pop_back());
        @(negedge clk);
        abort = 1'b0;
        wait_cyc(op_s + 40);
        start_op(8'd15, 8'd25, 8'd148);
        wait_cyc(op_s + 38);
`endif

        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_results: got %0d outstanding expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
